regfile_write_scheduler: RTL and testbench

- Shares the register file's single write port between two writeback sources: A = in-order pipeline writeback (priority), B = long-latency unit (load/mul/div) completion.
- Keeps a 32-entry busy scoreboard of registers awaiting a B result and raises a read stall for decode.
- Sits between the writeback stage and the register file; outputs drive its write, write_address and write_data inputs directly.

---
 rtl/regfile_write_scheduler.sv | 121 ++++++++++++
 tb/tb_regfile_write_scheduler.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : regfile_write_scheduler
// Brief    : Arbitrates the register-file write port between in-order
//            writeback (A) and a long-latency unit (B), and keeps a busy
//            scoreboard that raises the decode read stall.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_write_scheduler #(
    parameter int N        = 32,
    parameter int MAX_WAIT = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         a_valid,
    input  logic [4:0]   a_addr,
    input  logic [N-1:0] a_data,
    output logic         a_ready,
    input  logic         b_valid,
    input  logic [4:0]   b_addr,
    input  logic [N-1:0] b_data,
    output logic         b_ready,
    input  logic         issue_valid,
    input  logic [4:0]   issue_addr,
    input  logic [4:0]   rs1_addr,
    input  logic         rs1_used,
    input  logic [4:0]   rs2_addr,
    input  logic         rs2_used,
    output logic         stall,
    output logic         issue_conflict,
    output logic         rf_write,
    output logic [4:0]   rf_write_address,
    output logic [N-1:0] rf_write_data
);

    localparam logic [3:0] C_MAX_WAIT = 4'(MAX_WAIT);

    logic [31:0]  r_busy;
    logic [3:0]   r_starve_cnt;

    logic         w_grant_a;
    logic         w_grant_b;
    logic         w_xfer_b;
    logic         w_xfer;
    logic [4:0]   w_win_addr;
    logic [N-1:0] w_win_data;
    logic [31:0]  w_busy_next;
    logic         w_rs1_hit;
    logic         w_rs2_hit;

    // A has priority unless B has been refused MAX_WAIT cycles in a row.
    always_comb begin
        w_grant_a = 1'b0;
        w_grant_b = 1'b0;
        if (!reset) begin
            if (b_valid && (r_starve_cnt == C_MAX_WAIT)) begin
                w_grant_b = 1'b1;
            end else if (a_valid) begin
                w_grant_a = 1'b1;
            end else if (b_valid) begin
                w_grant_b = 1'b1;
            end
        end
    end

    assign a_ready    = w_grant_a;
    assign b_ready    = w_grant_b;
    assign w_xfer_b   = b_valid & w_grant_b;
    assign w_xfer     = (a_valid & w_grant_a) | w_xfer_b;
    assign w_win_addr = w_xfer_b ? b_addr : a_addr;
    assign w_win_data = w_xfer_b ? b_data : a_data;

    // Clear is applied before set so a same-cycle issue keeps the bit.
    always_comb begin
        w_busy_next = r_busy;
        if (w_xfer_b) begin
            w_busy_next[b_addr] = 1'b0;
        end
        if (issue_valid && (issue_addr != 5'd0)) begin
            w_busy_next[issue_addr] = 1'b1;
        end
        w_busy_next[0] = 1'b0;
    end

    // The in-flight term covers a write sitting in the output register.
    assign w_rs1_hit = rs1_used && (rs1_addr != 5'd0) &&
                       (r_busy[rs1_addr] || (rf_write && (rf_write_address == rs1_addr)));
    assign w_rs2_hit = rs2_used && (rs2_addr != 5'd0) &&
                       (r_busy[rs2_addr] || (rf_write && (rf_write_address == rs2_addr)));
    assign stall     = w_rs1_hit | w_rs2_hit;

    always_ff @(posedge clk) begin
        if (reset) begin
            rf_write         <= 1'b0;
            rf_write_address <= 5'd0;
            rf_write_data    <= '0;
            issue_conflict   <= 1'b0;
            r_busy           <= '0;
            r_starve_cnt     <= 4'd0;
        end else begin
            r_busy         <= w_busy_next;
            issue_conflict <= issue_valid && (issue_addr != 5'd0) && r_busy[issue_addr];

            if (!b_valid || w_xfer_b) begin
                r_starve_cnt <= 4'd0;
            end else if (r_starve_cnt != C_MAX_WAIT) begin
                r_starve_cnt <= r_starve_cnt + 4'd1;
            end

            if (w_xfer) begin
                rf_write_address <= w_win_addr;
                rf_write_data    <= w_win_data;
                rf_write         <= (w_win_addr != 5'd0);
            end else begin
                rf_write <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_write_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_write_scheduler
// Brief    : Directed and randomized bench for regfile_write_scheduler with an
//            in-bench behavioural model compared on every falling edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_write_scheduler;

    localparam int N        = 32;
    localparam int MAX_WAIT = 3;

    logic         clk = 1'b0;
    logic         reset;
    logic         a_valid, b_valid, issue_valid, rs1_used, rs2_used;
    logic [4:0]   a_addr, b_addr, issue_addr, rs1_addr, rs2_addr;
    logic [N-1:0] a_data, b_data;
    logic         a_ready, b_ready, stall, issue_conflict, rf_write;
    logic [4:0]   rf_write_address;
    logic [N-1:0] rf_write_data;

    int n_checks = 0;
    int n_fail   = 0;

    regfile_write_scheduler #(.N(N), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .reset(reset),
        .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
        .issue_valid(issue_valid), .issue_addr(issue_addr),
        .rs1_addr(rs1_addr), .rs1_used(rs1_used),
        .rs2_addr(rs2_addr), .rs2_used(rs2_used),
        .stall(stall), .issue_conflict(issue_conflict),
        .rf_write(rf_write), .rf_write_address(rf_write_address),
        .rf_write_data(rf_write_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit           m_busy [32];
    int           m_wait;          // consecutive cycles B has been refused
    bit           m_wr, m_conf, m_live, m_ga_last, m_gb_last;
    logic [4:0]   m_wa;
    logic [N-1:0] m_wd;

    function automatic void model_grant(output bit ga, output bit gb);
        ga = 0;
        gb = 0;
        if (reset) return;
        if (b_valid && m_wait >= MAX_WAIT) gb = 1;
        else if (a_valid)                  ga = 1;
        else if (b_valid)                  gb = 1;
    endfunction

    function automatic bit src_hit(input logic [4:0] a, input logic u);
        return u && a != 0 && (m_busy[a] || (m_wr && m_wa == a));
    endfunction

    always @(posedge clk) begin
        bit ga, gb;
        model_grant(ga, gb);
        m_ga_last = ga;
        m_gb_last = gb;
        if (reset) begin
            m_live = 1;
            foreach (m_busy[i]) m_busy[i] = 0;
            m_wait = 0;
            m_wr = 0; m_wa = 0; m_wd = 0; m_conf = 0;
        end else begin
            m_conf = issue_valid && issue_addr != 0 && m_busy[issue_addr];
            if (gb) m_busy[b_addr] = 0;
            if (issue_valid && issue_addr != 0) m_busy[issue_addr] = 1;
            if (ga || gb) begin
                m_wa = gb ? b_addr : a_addr;
                m_wd = gb ? b_data : a_data;
                m_wr = (m_wa != 0);
            end else begin
                m_wr = 0;
            end
            if (b_valid && !gb) m_wait = (m_wait + 1 > MAX_WAIT) ? MAX_WAIT : m_wait + 1;
            else                m_wait = 0;
        end
    end

    // Single compare process against the model.
    always @(negedge clk) begin
        bit ga, gb;
        if (m_live) begin
            model_grant(ga, gb);
            check("m_a_ready", a_ready, ga);
            check("m_b_ready", b_ready, gb);
            check("m_stall", stall, src_hit(rs1_addr, rs1_used) | src_hit(rs2_addr, rs2_used));
            check("m_rf_write", rf_write, m_wr);
            check("m_issue_conflict", issue_conflict, m_conf);
            if (m_wr) begin
                check("m_rf_addr", rf_write_address, m_wa);
                check("m_rf_data", rf_write_data, m_wd);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1; a_valid = 0; b_valid = 0; issue_valid = 0; rs1_used = 0; rs2_used = 0;
        a_addr = 0; b_addr = 0; issue_addr = 0; rs1_addr = 0; rs2_addr = 0;
        a_data = 0; b_data = 0;
        cyc(); cyc();
        a_valid = 1; #1;
        check("rst_a_ready", a_ready, 0);
        check("rst_rf_write", rf_write, 0);
        check("rst_rf_addr", rf_write_address, 0);
        check("rst_rf_data", rf_write_data, 0);
        check("rst_conflict", issue_conflict, 0);

        cyc(); reset = 0; a_valid = 0; issue_valid = 1; issue_addr = 5; #1;
        check("post_rst_rf_write", rf_write, 0);
        cyc(); issue_valid = 0; rs1_addr = 5; rs1_used = 1; #1;
        check("busy5_stall", stall, 1);
        check("busy5_conflict", issue_conflict, 0);

        cyc(); b_valid = 1; b_addr = 5; b_data = 32'hDEADBEEF; #1;
        check("b5_ready", b_ready, 1);
        check("b5_stall", stall, 1);
        cyc(); b_valid = 0; #1;
        check("b5_rf_write", rf_write, 1);
        check("b5_rf_addr", rf_write_address, 5);
        check("b5_rf_data", rf_write_data, 32'hDEADBEEF);
        check("b5_inflight_stall", stall, 1);
        cyc(); #1;
        check("b5_stall_clear", stall, 0);
        check("b5_rf_write_off", rf_write, 0);

        cyc(); rs1_used = 0;
        a_valid = 1; a_addr = 3; a_data = 32'hAAAA;
        b_valid = 1; b_addr = 4; b_data = 32'hBBBB;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("cont_a_ready", a_ready, (k != 3));
            check("cont_b_ready", b_ready, (k == 3));
            if (k == 4) begin
                check("cont_b_addr", rf_write_address, 4);
                check("cont_b_data", rf_write_data, 32'hBBBB);
            end
            cyc();
        end
        a_valid = 0; b_valid = 0;

        a_valid = 1; a_addr = 0; a_data = 32'h1234; rs1_addr = 0; rs1_used = 1; #1;
        check("x0_a_ready", a_ready, 1);
        check("x0_stall", stall, 0);
        cyc(); a_valid = 0; #1;
        check("x0_rf_write", rf_write, 0);

        cyc(); rs1_used = 0; issue_valid = 1; issue_addr = 7;
        cyc(); b_valid = 1; b_addr = 7; b_data = 32'h77; #1;
        check("sc_b_ready", b_ready, 1);
        cyc(); issue_valid = 0; b_valid = 0; rs1_addr = 7; rs1_used = 1; #1;
        check("sc_conflict", issue_conflict, 1);
        check("sc_stall", stall, 1);
        cyc(); #1;
        check("sc_conflict_pulse", issue_conflict, 0);
        check("sc_busy_kept", stall, 1);

        cyc(); rs1_used = 0; issue_valid = 1; issue_addr = 9;
        cyc(); issue_addr = 10; b_valid = 1; b_addr = 9; b_data = 32'h99; #1;
        check("rm_b_ready", b_ready, 1);
        cyc(); issue_valid = 0; b_valid = 0; reset = 1; #1;
        check("rm_rf_write_pending", rf_write, 1);
        cyc(); reset = 0; rs1_addr = 9; rs1_used = 1; rs2_addr = 10; rs2_used = 1; #1;
        check("rm_rf_write_cancel", rf_write, 0);
        check("rm_busy_dropped", stall, 0);

        for (int i = 0; i < 4000; i++) begin
            cyc();
            reset = ($urandom_range(0, 299) == 0);
            if (!(a_valid && !m_ga_last)) begin
                a_valid = ($urandom_range(0, 9) < 7);
                a_addr  = 5'($urandom);
                a_data  = $urandom;
            end
            if (!(b_valid && !m_gb_last)) begin
                b_valid = ($urandom_range(0, 1) == 1);
                b_addr  = 5'($urandom);
                b_data  = $urandom;
            end
            issue_valid = ($urandom_range(0, 3) == 0);
            issue_addr  = 5'($urandom);
            rs1_addr = 5'($urandom); rs1_used = 1'($urandom);
            rs2_addr = 5'($urandom); rs2_used = 1'($urandom);
        end
        cyc();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
